// File: rtl/root_scheduler_pkg.sv
// Shared types and sizes for the root-engine job scheduler.
package root_scheduler_pkg;

    localparam int RAD_W       = 10;
    localparam int DEG_W       = 3;
    localparam int DATA_W      = 20;
    localparam int CNT_W       = 7;
    localparam int DEF_TIMEOUT = 63;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_GAP
    } state_t;

endpackage

// File: rtl/root_scheduler_rr_arb2.sv
// Two-way round-robin arbiter; the last winner loses the next tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant
);

    // index of the requester that wins a tie
    logic prio;

    always_comb begin
        grant = req;
        if (req == 2'b11)
            grant = prio ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            prio <= 1'b0;
        else if (en && |req)
            prio <= grant[0];
    end

endmodule

// File: rtl/root_scheduler.sv
// Serialises root jobs from two requesters onto one root engine,
// with degree-0 rejection and an engine timeout.
module root_scheduler
    import root_scheduler_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0][RAD_W-1:0] req_radicand,
    input  logic [1:0][DEG_W-1:0] req_degree,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_err,
    output logic                  eng_in_valid,
    output logic [RAD_W-1:0]      eng_in_data_1,
    output logic [DEG_W-1:0]      eng_in_data_2,
    input  logic                  eng_out_valid,
    input  logic [DATA_W-1:0]     eng_out_data
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic             owner;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       grant;
    logic             idle;
    logic             win;

    assign idle      = (state == S_IDLE);
    assign win       = grant[1];
    assign req_ready = idle ? grant : 2'b00;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_valid),
        .en    (idle),
        .grant (grant)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            owner         <= 1'b0;
            cnt           <= '0;
            rsp_valid     <= 2'b00;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
            eng_in_valid  <= 1'b0;
            eng_in_data_1 <= '0;
            eng_in_data_2 <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (|req_valid) begin
                        owner <= win;
                        cnt   <= '0;
                        // degree 0 has no root: answer without the engine
                        if (req_degree[win] == '0) begin
                            state     <= S_RESP;
                            rsp_valid <= win ? 2'b10 : 2'b01;
                            rsp_data  <= '0;
                            rsp_err   <= 1'b1;
                        end else begin
                            state         <= S_ISSUE;
                            eng_in_valid  <= 1'b1;
                            eng_in_data_1 <= req_radicand[win];
                            eng_in_data_2 <= req_degree[win];
                        end
                    end
                end
                S_ISSUE: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        eng_in_valid <= 1'b0;
                        state        <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (eng_out_valid) begin
                        state         <= S_RESP;
                        rsp_valid     <= owner ? 2'b10 : 2'b01;
                        rsp_data      <= eng_out_data;
                        rsp_err       <= 1'b0;
                        eng_in_data_1 <= '0;
                        eng_in_data_2 <= '0;
                    end else if (cnt == LAST_CNT) begin
                        state         <= S_RESP;
                        rsp_valid     <= owner ? 2'b10 : 2'b01;
                        rsp_data      <= '0;
                        rsp_err       <= 1'b1;
                        eng_in_data_1 <= '0;
                        eng_in_data_2 <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid <= 2'b00;
                        state     <= S_GAP;
                    end
                end
                S_GAP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_root_scheduler.sv
// Random two-requester traffic against a cycle-number reference model
// and a behavioural root engine with per-job latency.
module tb_root_scheduler;

    localparam int TIMEOUT = 63;
    localparam int NCYC    = 3000;
    localparam int RST_AT  = 1500;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][9:0]  req_radicand;
    logic [1:0][2:0]  req_degree;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [19:0]      rsp_data;
    logic             rsp_err;
    logic             eng_in_valid;
    logic [9:0]       eng_in_data_1;
    logic [2:0]       eng_in_data_2;
    logic             eng_out_valid;
    logic [19:0]      eng_out_data;

    root_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_radicand  (req_radicand),
        .req_degree    (req_degree),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .eng_in_valid  (eng_in_valid),
        .eng_in_data_1 (eng_in_data_1),
        .eng_in_data_2 (eng_in_data_2),
        .eng_out_valid (eng_out_valid),
        .eng_out_data  (eng_out_data)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %0h expected %0h at cycle %0d",
                         tag, got, exp, cyc);
        end
    endtask

    // largest r with r**deg <= rad
    function automatic int iroot(input int rad, input int deg);
        int r = 0;
        for (int k = 1; k <= rad; k++) begin
            longint p = 1;
            for (int j = 0; j < deg; j++) p = p * k;
            if (p <= rad) r = k;
            else break;
        end
        return r;
    endfunction

    function automatic logic [1:0] winner(input logic [1:0] v,
                                          input bit tie);
        if (v == 2'b11) return tie ? 2'b10 : 2'b01;
        return v;
    endfunction

    task automatic check_reset_outputs(input string p);
        chk({p, "_req_ready"}, 32'(req_ready), 0);
        chk({p, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({p, "_rsp_data"},  32'(rsp_data), 0);
        chk({p, "_rsp_err"},   32'(rsp_err), 0);
        chk({p, "_eng_iv"},    32'(eng_in_valid), 0);
        chk({p, "_eng_d1"},    32'(eng_in_data_1), 0);
        chk({p, "_eng_d2"},    32'(eng_in_data_2), 0);
    endtask

    // reference model: job described by cycle numbers
    bit          m_busy, m_owner, m_ptr;
    int          m_free_at, m_c, m_rsp_from, m_eng_end, m_lat;
    logic [9:0]  m_rad;
    logic [2:0]  m_deg;
    logic [19:0] m_data;
    bit          m_err;
    int          eng_jobs;
    int          lat_list[4] = '{2, 60, 61, 0};

    // engine model
    int          fire_at, hi_cnt;
    logic [19:0] fire_data;

    // requesters
    bit          rv[2];
    logic [9:0]  rq_rad[2];
    logic [2:0]  rq_deg[2];
    int          nreq[2];
    int          t_rad[2][2] = '{'{64, 100}, '{1000, 27}};
    int          t_deg[2][2] = '{'{2, 0}, '{1, 3}};

    bit          rst_req, post_rst, rst_done;

    task automatic model_reset(input int from);
        m_busy = 0; m_ptr = 0; m_free_at = from;
        fire_at = -1; hi_cnt = 0;
        rv[0] = 0; rv[1] = 0;
    endtask

    task automatic new_req(input int i);
        if (nreq[i] < 2) begin
            rv[i] = 1;
            rq_rad[i] = 10'(t_rad[i][nreq[i]]);
            rq_deg[i] = 3'(t_deg[i][nreq[i]]);
        end else if ($urandom_range(0, 1) == 1) begin
            rv[i] = 1;
            rq_rad[i] = 10'($urandom_range(0, 1023));
            rq_deg[i] = 3'($urandom_range(0, 7));
        end
        if (rv[i]) nreq[i]++;
    endtask

    function automatic int pick_lat();
        if (eng_jobs < 4) return lat_list[eng_jobs];
        if ($urandom_range(0, 9) < 7) return $urandom_range(0, 8);
        return $urandom_range(56, 68);
    endfunction

    initial begin
        logic [1:0] e_ready, e_rsp;
        bit         e_iv, held, free;
        int         w, e;

        rst_n = 0; req_valid = 0; req_radicand = '0; req_degree = '0;
        rsp_ready = 0; eng_out_valid = 0; eng_out_data = 0;
        nreq[0] = 0; nreq[1] = 0; eng_jobs = 0;
        rst_req = 0; post_rst = 0; rst_done = 0;
        model_reset(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        new_req(0); new_req(1);
        @(posedge clk); #1;

        for (int s = 0; s < NCYC; s++) begin
            rst_n = !rst_req;
            for (int i = 0; i < 2; i++) begin
                req_valid[i]    = rv[i];
                req_radicand[i] = rq_rad[i];
                req_degree[i]   = rq_deg[i];
            end
            rsp_ready[0]  = ($urandom_range(0, 3) == 0);
            rsp_ready[1]  = ($urandom_range(0, 3) == 0);
            eng_out_valid = (cyc == fire_at);
            eng_out_data  = eng_out_valid ? fire_data
                                          : 20'($urandom);
            @(negedge clk);

            if (post_rst) check_reset_outputs("wait_rst");

            free    = !m_busy && cyc >= m_free_at;
            e_ready = free ? winner(req_valid, m_ptr) : 2'b00;
            e_iv    = m_busy && m_deg != 0 &&
                      (cyc == m_c + 1 || cyc == m_c + 2);
            held    = m_busy && m_deg != 0 &&
                      cyc >= m_c + 1 && cyc <= m_eng_end;
            e_rsp   = (m_busy && cyc >= m_rsp_from) ?
                      (m_owner ? 2'b10 : 2'b01) : 2'b00;
            chk("req_ready", 32'(req_ready), 32'(e_ready));
            chk("eng_in_valid", 32'(eng_in_valid), 32'(e_iv));
            chk("eng_d1", 32'(eng_in_data_1), held ? 32'(m_rad) : 0);
            chk("eng_d2", 32'(eng_in_data_2), held ? 32'(m_deg) : 0);
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
            if (e_rsp != 0) begin
                chk("rsp_data", 32'(rsp_data), 32'(m_data));
                chk("rsp_err", 32'(rsp_err), 32'(m_err));
            end

            // engine: two in_valid cycles, then L idle cycles
            if (eng_in_valid) begin
                hi_cnt++;
                fire_at = -1;
                fire_data = 20'(iroot(int'(eng_in_data_1),
                                      int'(eng_in_data_2)) << 10);
                if (hi_cnt == 2) fire_at = cyc + 1 + m_lat;
            end else begin
                hi_cnt = 0;
            end

            if (m_busy && cyc >= m_rsp_from && rsp_ready[m_owner]) begin
                m_busy = 0;
                m_free_at = cyc + 2;
            end
            if (e_ready != 0 && !rst_req) begin
                w = int'(e_ready[1]);
                m_busy = 1; m_c = cyc; m_owner = e_ready[1];
                m_ptr = (w == 0);
                m_rad = req_radicand[w]; m_deg = req_degree[w];
                if (m_deg == 0) begin
                    m_rsp_from = cyc + 1; m_eng_end = cyc;
                    m_data = 0; m_err = 1;
                end else begin
                    m_lat = pick_lat();
                    eng_jobs++;
                    e = cyc + 3 + m_lat;
                    if (m_lat + 3 <= TIMEOUT) begin
                        m_rsp_from = e + 1; m_eng_end = e;
                        m_data = 20'(iroot(int'(m_rad), int'(m_deg))
                                     << 10);
                        m_err = 0;
                    end else begin
                        m_rsp_from = cyc + TIMEOUT + 1;
                        m_eng_end = cyc + TIMEOUT;
                        m_data = 0; m_err = 1;
                    end
                end
            end

            post_rst = 0;
            if (rst_req) begin
                model_reset(cyc + 1);
                rst_req = 0; post_rst = 1; rst_done = 1;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (rv[i] && req_ready[i]) rv[i] = 0;
                    if (!rv[i]) new_req(i);
                end
                if (!rst_done && cyc >= RST_AT && m_busy &&
                    m_deg != 0 && cyc >= m_c + 3 &&
                    cyc + 1 < m_eng_end)
                    rst_req = 1;
            end

            @(posedge clk); #1;
            cyc++;
        end

        chk("reset_exercised", 32'(rst_done), 1);
        chk("jobs_seen", 32'(eng_jobs > 20), 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
